fpu_csr_file: RTL and testbench

Per-warp floating-point CSR storage: the responder side of the FPU CSR interface driven by each FPU execution block. Holds the per-warp `frm` and accrued `fflags` state. Serves dynamic-rounding-mode lookups and fflags accumulation from the FPU blocks. Services CSR-instruction accesses to `fflags`/`frm`/`fcsr`, and stalls flag-sensitive accesses until that warp's in-flight FPU operations have drained.

---
 rtl/fpu_csr_file_if.sv | 24 ++
 rtl/fpu_csr_file.sv | 217 +++++++++++++++++++++
 tb/tb_fpu_csr_file.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_csr_file_if.sv
// rtl/fpu_csr_file_if.sv - CSR request/response handshake bundle for the FPU CSR file
interface fpu_csr_file_if #(
  parameter int NW_WIDTH = 2
);
  logic                csr_req_valid;
  logic                csr_req_ready;
  logic [NW_WIDTH-1:0] csr_req_wid;
  logic [11:0]         csr_req_addr;
  logic [1:0]          csr_req_op;
  logic [7:0]          csr_req_wdata;
  logic                csr_rsp_valid;
  logic                csr_rsp_ready;
  logic [31:0]         csr_rsp_data;

  modport master (
    output csr_req_valid, csr_req_wid, csr_req_addr, csr_req_op, csr_req_wdata, csr_rsp_ready,
    input  csr_req_ready, csr_rsp_valid, csr_rsp_data
  );

  modport slave (
    input  csr_req_valid, csr_req_wid, csr_req_addr, csr_req_op, csr_req_wdata, csr_rsp_ready,
    output csr_req_ready, csr_rsp_valid, csr_rsp_data
  );
endinterface

// File: rtl/fpu_csr_file.sv
// rtl/fpu_csr_file.sv - per-warp frm/fflags storage with drain-aware CSR access FSM
module fpu_csr_file #(
  parameter int NUM_WARPS      = 4,
  parameter int NUM_FPU_BLOCKS = 1,
  parameter int FPUQ_SIZE      = 8,
  localparam int NW_WIDTH      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int PEND_W        = $clog2(NUM_FPU_BLOCKS * FPUQ_SIZE + 1)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_FPU_BLOCKS-1:0][NW_WIDTH-1:0]  read_wid,
  output logic [NUM_FPU_BLOCKS-1:0][2:0]           read_frm,
  input  logic [NUM_FPU_BLOCKS-1:0]                write_enable,
  input  logic [NUM_FPU_BLOCKS-1:0][NW_WIDTH-1:0]  write_wid,
  input  logic [NUM_FPU_BLOCKS-1:0][4:0]           write_fflags,
  input  logic                                     pend_inc_valid,
  input  logic [NW_WIDTH-1:0]                      pend_inc_wid,
  input  logic [NUM_FPU_BLOCKS-1:0]                pend_dec_valid,
  input  logic [NUM_FPU_BLOCKS-1:0][NW_WIDTH-1:0]  pend_dec_wid,
  fpu_csr_file_if.slave                            csr,
  output logic                                     err
);

  localparam int          PEND_MAX    = (1 << PEND_W) - 1;
  localparam logic [11:0] ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] ADDR_FRM    = 12'h002;
  localparam logic [11:0] ADDR_FCSR   = 12'h003;
  localparam logic [1:0]  OP_READ     = 2'd0;
  localparam logic [1:0]  OP_WRITE    = 2'd1;
  localparam logic [1:0]  OP_SET      = 2'd2;
  localparam logic [1:0]  OP_CLEAR    = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state_q, state_d;

  logic [4:0]        fflags_q [NUM_WARPS];
  logic [2:0]        frm_q    [NUM_WARPS];
  logic [PEND_W-1:0] pend_q   [NUM_WARPS];
  logic [4:0]        acc_ff   [NUM_WARPS];
  int                pend_sum [NUM_WARPS];
  logic              pend_err;

  logic [NW_WIDTH-1:0] lat_wid;
  logic [11:0]         lat_addr;
  logic [1:0]          lat_op;
  logic [7:0]          lat_wdata;
  logic [31:0]         rsp_data_q;

  logic        req_ready, rsp_valid, exec, exempt;
  logic [31:0] old_data;
  logic [4:0]  new_ff, cur_ff, ff_opnd;
  logic [2:0]  new_fr, cur_fr, fr_opnd;
  logic        upd_ff, upd_fr;

  assign csr.csr_req_ready = req_ready;
  assign csr.csr_rsp_valid = rsp_valid;
  assign csr.csr_rsp_data  = rsp_data_q;

  // Per-block frm lookup, straight from the warp's register.
  always_comb begin
    for (int b = 0; b < NUM_FPU_BLOCKS; b++) begin
      read_frm[b] = frm_q[read_wid[b]];
    end
  end

  // Merge flags from every FPU block that targets each warp this cycle.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      acc_ff[w] = '0;
      for (int b = 0; b < NUM_FPU_BLOCKS; b++) begin
        if (write_enable[b] && write_wid[b] == NW_WIDTH'(w)) begin
          acc_ff[w] = acc_ff[w] | write_fflags[b];
        end
      end
    end
  end

  // Net pending-count update per warp; out-of-range results flag an error.
  always_comb begin
    pend_err = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      pend_sum[w] = int'(pend_q[w]);
      if (pend_inc_valid && pend_inc_wid == NW_WIDTH'(w)) begin
        pend_sum[w] = pend_sum[w] + 1;
      end
      for (int b = 0; b < NUM_FPU_BLOCKS; b++) begin
        if (pend_dec_valid[b] && pend_dec_wid[b] == NW_WIDTH'(w)) begin
          pend_sum[w] = pend_sum[w] - 1;
        end
      end
      if (pend_sum[w] < 0 || pend_sum[w] > PEND_MAX) begin
        pend_err = 1'b1;
      end
    end
  end

  // Old value and updated fields for the latched CSR access.
  always_comb begin
    cur_ff   = fflags_q[lat_wid];
    cur_fr   = frm_q[lat_wid];
    ff_opnd  = lat_wdata[4:0];
    fr_opnd  = (lat_addr == ADDR_FCSR) ? lat_wdata[7:5] : lat_wdata[2:0];
    old_data = '0;
    upd_ff   = 1'b0;
    upd_fr   = 1'b0;
    new_ff   = cur_ff;
    new_fr   = cur_fr;
    case (lat_addr)
      ADDR_FFLAGS: begin
        old_data = {27'b0, cur_ff};
        upd_ff   = (lat_op != OP_READ);
      end
      ADDR_FRM: begin
        old_data = {29'b0, cur_fr};
        upd_fr   = (lat_op != OP_READ);
      end
      ADDR_FCSR: begin
        old_data = {24'b0, cur_fr, cur_ff};
        upd_ff   = (lat_op != OP_READ);
        upd_fr   = (lat_op != OP_READ);
      end
      default: ;
    endcase
    case (lat_op)
      OP_WRITE: begin
        new_ff = ff_opnd;
        new_fr = fr_opnd;
      end
      OP_SET: begin
        new_ff = cur_ff | ff_opnd;
        new_fr = cur_fr | fr_opnd;
      end
      OP_CLEAR: begin
        new_ff = cur_ff & ~ff_opnd;
        new_fr = cur_fr & ~fr_opnd;
      end
      default: ;
    endcase
  end

  // frm accesses never depend on in-flight flag producers, so they skip the drain.
  assign exempt = (lat_addr == ADDR_FRM);

  // CSR access FSM: next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    exec      = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (csr.csr_req_valid) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (exempt || pend_q[lat_wid] == '0) begin
          exec    = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (csr.csr_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Capture the request on acceptance and the old value at execution.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_wid    <= '0;
      lat_addr   <= '0;
      lat_op     <= '0;
      lat_wdata  <= '0;
      rsp_data_q <= '0;
    end else begin
      if (req_ready && csr.csr_req_valid) begin
        lat_wid   <= csr.csr_req_wid;
        lat_addr  <= csr.csr_req_addr;
        lat_op    <= csr.csr_req_op;
        lat_wdata <= csr.csr_req_wdata;
      end
      if (exec) rsp_data_q <= old_data;
    end
  end

  // Per-warp state: CSR update merged with FPU flag accumulation, pending counters, sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        fflags_q[w] <= '0;
        frm_q[w]    <= '0;
        pend_q[w]   <= '0;
      end
      err <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (exec && upd_ff && lat_wid == NW_WIDTH'(w)) fflags_q[w] <= new_ff | acc_ff[w];
        else                                          fflags_q[w] <= fflags_q[w] | acc_ff[w];
        if (exec && upd_fr && lat_wid == NW_WIDTH'(w)) frm_q[w] <= new_fr;
        if (pend_sum[w] < 0)             pend_q[w] <= '0;
        else if (pend_sum[w] > PEND_MAX) pend_q[w] <= pend_q[w];
        else                             pend_q[w] <= PEND_W'(pend_sum[w]);
      end
      if (pend_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_csr_file.sv
// tb/tb_fpu_csr_file.sv - scoreboard bench for fpu_csr_file
module tb_fpu_csr_file;
  localparam int NW  = 4;
  localparam int NB  = 2;
  localparam int NWW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NB-1:0][NWW-1:0] read_wid, write_wid, pend_dec_wid;
  logic [NB-1:0][2:0]     read_frm;
  logic [NB-1:0]          write_enable, pend_dec_valid;
  logic [NB-1:0][4:0]     write_fflags;
  logic                   pend_inc_valid;
  logic [NWW-1:0]         pend_inc_wid;
  logic                   err;

  fpu_csr_file_if #(.NW_WIDTH(NWW)) csr_if ();

  fpu_csr_file #(.NUM_WARPS(NW), .NUM_FPU_BLOCKS(NB), .FPUQ_SIZE(8)) dut (
    .clk(clk), .reset(reset),
    .read_wid(read_wid), .read_frm(read_frm),
    .write_enable(write_enable), .write_wid(write_wid), .write_fflags(write_fflags),
    .pend_inc_valid(pend_inc_valid), .pend_inc_wid(pend_inc_wid),
    .pend_dec_valid(pend_dec_valid), .pend_dec_wid(pend_dec_wid),
    .csr(csr_if.slave), .err(err)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [4:0]  m_ff  [NW];
  logic [2:0]  m_frm [NW];
  logic [31:0] exp_q [$];
  string       name_q[$];
  bit          rand_ready = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: fcsr seen as an 8-bit value, each CSR address a bit-field of it.
  function automatic logic [31:0] model_csr(input int w, input int addr, input int op, input logic [7:0] wd);
    int v, lo, mask, old, opd, nv;
    v = int'(m_frm[w]) * 32 + int'(m_ff[w]);
    case (addr)
      1: begin lo = 0; mask = 31;  end
      2: begin lo = 5; mask = 7;   end
      3: begin lo = 0; mask = 255; end
      default: return 32'd0;
    endcase
    old = (v >> lo) & mask;
    opd = int'(wd) & mask;
    case (op)
      0: nv = old;
      1: nv = opd;
      2: nv = old | opd;
      default: nv = old & ~opd;
    endcase
    v = (v & ~(mask << lo)) | ((nv & mask) << lo);
    m_ff[w]  = 5'(v % 32);
    m_frm[w] = 3'((v / 32) % 8);
    return 32'(old);
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      m_ff[w]  = '0;
      m_frm[w] = '0;
    end
  endtask

  task automatic push_exp(input string nm, input logic [31:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  // Monitor: every accepted response is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && csr_if.csr_rsp_valid && csr_if.csr_rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_rsp: got data 0x%0h, expected no response", csr_if.csr_rsp_data);
      end else begin
        check(name_q.pop_front(), csr_if.csr_rsp_data, exp_q.pop_front());
      end
    end
  end

  // Random response backpressure during the random phase.
  always @(posedge clk) begin
    #1;
    if (rand_ready) csr_if.csr_rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int w, input int addr, input int op, input logic [7:0] wd);
    bit got;
    got = 1'b0;
    csr_if.csr_req_valid = 1'b1;
    csr_if.csr_req_wid   = NWW'(w);
    csr_if.csr_req_addr  = 12'(addr);
    csr_if.csr_req_op    = 2'(op);
    csr_if.csr_req_wdata = wd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (csr_if.csr_req_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!got) begin
      n_checks++;
      n_fails++;
      $display("FAIL req_ready_timeout: got ready 0, expected 1 within 50 cycles");
    end
    tick();
    csr_if.csr_req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fails++;
      $display("FAIL rsp_timeout: got %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
    #1;
  endtask

  task automatic clear_fpu();
    write_enable   = '0;
    pend_dec_valid = '0;
    pend_inc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    reset = 1'b1;
    read_wid = '0; write_wid = '0; pend_dec_wid = '0; write_fflags = '0;
    pend_inc_wid = '0;
    clear_fpu();
    csr_if.csr_req_valid = 1'b0; csr_if.csr_req_wid = '0; csr_if.csr_req_addr = '0;
    csr_if.csr_req_op = '0; csr_if.csr_req_wdata = '0; csr_if.csr_rsp_ready = 1'b1;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    read_wid[1] = 2'd3;
    @(negedge clk);
    check("rst_req_ready", 32'(csr_if.csr_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(csr_if.csr_rsp_valid), 32'd0);
    check("rst_rsp_data", csr_if.csr_rsp_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_read_frm0", 32'(read_frm[0]), 32'd0);
    check("rst_read_frm1", 32'(read_frm[1]), 32'd0);
    tick();

    // fcsr read of warp 0 with minimum latency
    push_exp("fcsr_rd_w0", model_csr(0, 3, 0, 8'h00));
    issue(0, 3, 0, 8'h00);
    @(negedge clk);
    check("lat_c1_rsp_valid", 32'(csr_if.csr_rsp_valid), 32'd0);
    check("lat_c1_req_ready", 32'(csr_if.csr_req_ready), 32'd0);
    @(negedge clk);
    check("lat_c2_rsp_valid", 32'(csr_if.csr_rsp_valid), 32'd1);
    wait_drain();

    // frm write to warp 2, visible on read_frm the cycle after EXEC
    read_wid[0] = 2'd2;
    read_wid[1] = 2'd1;
    push_exp("frm_wr_w2", model_csr(2, 2, 1, 8'h03));
    issue(2, 2, 1, 8'h03);
    @(posedge clk);
    @(negedge clk);
    check("read_frm_w2", 32'(read_frm[0]), 32'(m_frm[2]));
    check("read_frm_w1", 32'(read_frm[1]), 32'd0);
    wait_drain();

    // two blocks accumulate into warp 1 on the same cycle
    write_enable = 2'b11;
    write_wid[0] = 2'd1; write_fflags[0] = 5'b00001;
    write_wid[1] = 2'd1; write_fflags[1] = 5'b10000;
    tick();
    clear_fpu();
    m_ff[1] = m_ff[1] | 5'b10001;
    push_exp("ff_merge_w1", model_csr(1, 1, 0, 8'h00));
    issue(1, 1, 0, 8'h00);
    wait_drain();

    // fcsr set then clear on warp 0
    push_exp("ff_wr_w0", model_csr(0, 1, 1, 8'h02));
    issue(0, 1, 1, 8'h02);
    wait_drain();
    push_exp("fcsr_set_w0", model_csr(0, 3, 2, 8'hE1));
    issue(0, 3, 2, 8'hE1);
    wait_drain();
    read_wid[0] = 2'd0;
    @(negedge clk);
    check("read_frm_w0_set", 32'(read_frm[0]), 32'd7);
    tick();
    push_exp("fcsr_clr_w0", model_csr(0, 3, 3, 8'h03));
    issue(0, 3, 3, 8'h03);
    wait_drain();
    push_exp("ff_rd_w0_after_clr", model_csr(0, 1, 0, 8'h00));
    issue(0, 1, 0, 8'h00);
    wait_drain();

    // fflags read on warp 3 held until two in-flight ops retire
    pend_inc_valid = 1'b1;
    pend_inc_wid   = 2'd3;
    tick();
    tick();
    clear_fpu();
    issue(3, 1, 0, 8'h00);
    repeat (4) @(negedge clk);
    check("drain_hold_rsp_valid", 32'(csr_if.csr_rsp_valid), 32'd0);
    check("drain_hold_req_ready", 32'(csr_if.csr_req_ready), 32'd0);
    tick();
    pend_dec_valid[0] = 1'b1; pend_dec_wid[0] = 2'd3;
    tick();
    clear_fpu();
    pend_dec_valid[1] = 1'b1; pend_dec_wid[1] = 2'd3;
    write_enable[1] = 1'b1; write_wid[1] = 2'd3; write_fflags[1] = 5'b00100;
    tick();
    clear_fpu();
    m_ff[3] = m_ff[3] | 5'b00100;
    push_exp("drain_rd_w3", model_csr(3, 1, 0, 8'h00));
    @(negedge clk);
    check("drain_exec_rsp_valid", 32'(csr_if.csr_rsp_valid), 32'd0);
    @(negedge clk);
    check("drain_rsp_valid", 32'(csr_if.csr_rsp_valid), 32'd1);
    check("drain_err", 32'(err), 32'd0);
    wait_drain();

    // decrement below zero sets sticky err
    pend_dec_valid[0] = 1'b1; pend_dec_wid[0] = 2'd0;
    tick();
    clear_fpu();
    @(negedge clk);
    check("underflow_err", 32'(err), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    check("underflow_err_sticky", 32'(err), 32'd1);
    tick();

    // reset during a WAIT-state access drops it
    pend_inc_valid = 1'b1; pend_inc_wid = 2'd1;
    tick();
    clear_fpu();
    issue(1, 1, 0, 8'h00);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("abort_err", 32'(err), 32'd0);
    check("abort_req_ready", 32'(csr_if.csr_req_ready), 32'd1);
    check("abort_rsp_valid", 32'(csr_if.csr_rsp_valid), 32'd0);
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    read_wid[0] = 2'd2;
    repeat (4) tick();
    @(negedge clk);
    check("abort_no_rsp", 32'(csr_if.csr_rsp_valid), 32'd0);
    check("abort_frm_cleared", 32'(read_frm[0]), 32'd0);
    tick();

    // random accumulate / CSR traffic with response backpressure
    rand_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int ncyc, w, addr, op;
      logic [7:0] wd;
      ncyc = int'($urandom_range(0, 2));
      for (int c = 0; c < ncyc; c++) begin
        for (int b = 0; b < NB; b++) begin
          write_enable[b] = 1'($urandom_range(0, 1));
          write_wid[b]    = 2'($urandom_range(0, NW - 1));
          write_fflags[b] = 5'($urandom);
        end
        tick();
        for (int b = 0; b < NB; b++) begin
          if (write_enable[b]) m_ff[write_wid[b]] = m_ff[write_wid[b]] | write_fflags[b];
        end
        clear_fpu();
      end
      read_wid[0] = 2'($urandom_range(0, NW - 1));
      read_wid[1] = 2'($urandom_range(0, NW - 1));
      @(negedge clk);
      check("rand_read_frm0", 32'(read_frm[0]), 32'(m_frm[read_wid[0]]));
      check("rand_read_frm1", 32'(read_frm[1]), 32'(m_frm[read_wid[1]]));
      tick();
      w    = int'($urandom_range(0, NW - 1));
      case ($urandom_range(0, 5))
        0: addr = 0;
        1: addr = 1;
        2: addr = 2;
        3: addr = 3;
        4: addr = 4;
        default: addr = 12'h7FF;
      endcase
      op   = int'($urandom_range(0, 3));
      wd   = 8'($urandom);
      e    = model_csr(w, addr, op, wd);
      push_exp("rand_csr", e);
      issue(w, addr, op, wd);
      wait_drain();
    end
    rand_ready = 1'b0;
    csr_if.csr_rsp_ready = 1'b1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
